// File: rtl/axi_llc_tag_lookup_if.sv
// Request/response handshake bundle between the LLC pipeline and the tag lookup controller.
interface axi_llc_tag_lookup_if #(
    parameter int unsigned NumWays  = 32'd8,
    parameter int unsigned NumLines = 32'd256,
    parameter int unsigned TagWidth = 32'd20,
    parameter int unsigned IdxWidth = (NumLines > 32'd1) ? $clog2(NumLines) : 32'd1
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [1:0]          req_op_i;
    logic [IdxWidth-1:0] req_idx_i;
    logic [TagWidth-1:0] req_tag_i;
    logic [NumWays-1:0]  req_way_i;
    logic                req_dirty_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic                rsp_hit_o;
    logic [NumWays-1:0]  rsp_way_o;
    logic                rsp_dirty_o;
    logic                rsp_evict_o;
    logic [TagWidth-1:0] rsp_tag_o;
    logic                rsp_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_idx_i, req_tag_i, req_way_i, req_dirty_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_dirty_o, rsp_evict_o,
               rsp_tag_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_idx_i, req_tag_i, req_way_i, req_dirty_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_dirty_o, rsp_evict_o,
               rsp_tag_o, rsp_err_o
    );
endinterface

// File: rtl/axi_llc_tag_lookup.sv
// LLC tag lookup controller: parallel read of all way tag SRAMs, compare, optional
// single-way write-back, and a post-reset sweep that zeroes every entry.
module axi_llc_tag_lookup #(
    parameter  int unsigned NumWays  = 32'd8,
    parameter  int unsigned NumLines = 32'd256,
    parameter  int unsigned TagWidth = 32'd20,
    localparam int unsigned IdxWidth = (NumLines > 32'd1) ? $clog2(NumLines) : 32'd1,
    localparam int unsigned EntryW   = TagWidth + 32'd2,
    localparam int unsigned BeW      = (EntryW + 32'd7) / 32'd8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    axi_llc_tag_lookup_if.slave          bus,
    output logic                         init_done_o,
    output logic [NumWays-1:0]           sram_req_o,
    output logic [NumWays-1:0]           sram_we_o,
    output logic [NumWays*IdxWidth-1:0]  sram_addr_o,
    output logic [NumWays*EntryW-1:0]    sram_wdata_o,
    output logic [NumWays*BeW-1:0]       sram_be_o,
    input  logic [NumWays*EntryW-1:0]    sram_rdata_i
);
    localparam logic [1:0]          OP_LDIRTY = 2'b01;
    localparam logic [1:0]          OP_FILL   = 2'b10;
    localparam logic [1:0]          OP_INVAL  = 2'b11;
    localparam logic [IdxWidth-1:0] LastIdx   = IdxWidth'(NumLines - 32'd1);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;

    state_e              r_state;
    logic [IdxWidth-1:0] r_cnt;
    logic                r_init_done;
    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic [NumWays-1:0]  r_rsp_way;
    logic                r_rsp_dirty;
    logic                r_rsp_evict;
    logic [TagWidth-1:0] r_rsp_tag;
    logic                r_rsp_err;

    logic [1:0]          r_op;
    logic [IdxWidth-1:0] r_idx;
    logic [TagWidth-1:0] r_tag;
    logic [NumWays-1:0]  r_way;
    logic                r_dirty;
    logic [NumWays-1:0]  r_tgt;
    logic [EntryW-1:0]   r_wentry;

    logic [EntryW-1:0]   w_entry [NumWays];
    logic [NumWays-1:0]  w_match;
    logic [NumWays-1:0]  w_dirty;
    logic [EntryW-1:0]   w_vict;
    logic                w_err;
    logic                w_hit;
    logic                w_hit_dirty;
    logic                w_need_wr;
    logic [NumWays-1:0]  w_tgt;
    logic [EntryW-1:0]   w_wentry;
    logic                w_accept;
    logic [IdxWidth-1:0] w_addr;
    logic [EntryW-1:0]   w_wdata;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid_i;

    for (genvar w = 0; w < NumWays; w++) begin : g_way
        assign w_entry[w] = sram_rdata_i[w*EntryW +: EntryW];
        assign w_match[w] = w_entry[w][EntryW-1] && (w_entry[w][TagWidth-1:0] == r_tag);
        assign w_dirty[w] = w_entry[w][EntryW-2];
    end

    // Victim entry selected by the one-hot FILL way
    always_comb begin
        w_vict = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (r_way[w]) w_vict = w_vict | w_entry[w];
        end
    end

    assign w_err       = ($countones(w_match) > 1);
    assign w_hit       = (w_match != '0) && !w_err;
    assign w_hit_dirty = |(w_match & w_dirty);
    assign w_tgt       = (r_op == OP_FILL) ? r_way : w_match;

    always_comb begin
        w_need_wr = 1'b0;
        w_wentry  = '0;
        case (r_op)
            OP_LDIRTY: begin
                w_need_wr = w_hit && !w_hit_dirty;
                w_wentry  = {1'b1, 1'b1, r_tag};
            end
            OP_INVAL: w_need_wr = w_hit;
            OP_FILL: begin
                w_need_wr = !w_err;
                w_wentry  = {1'b1, r_dirty, r_tag};
            end
            default: w_need_wr = 1'b0;
        endcase
    end

    always_comb begin
        sram_req_o = '0;
        sram_we_o  = '0;
        w_addr     = '0;
        w_wdata    = '0;
        case (r_state)
            ST_INIT: begin
                sram_req_o = '1;
                sram_we_o  = '1;
                w_addr     = r_cnt;
            end
            ST_IDLE: begin
                if (bus.req_valid_i) sram_req_o = '1;
                w_addr = bus.req_idx_i;
            end
            ST_WRITE: begin
                sram_req_o = r_tgt;
                sram_we_o  = r_tgt;
                w_addr     = r_idx;
                w_wdata    = r_wentry;
            end
            default: w_addr = r_idx;
        endcase
    end

    assign sram_addr_o  = {NumWays{w_addr}};
    assign sram_wdata_o = {NumWays{w_wdata}};
    assign sram_be_o    = '1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_way   <= '0;
            r_rsp_dirty <= 1'b0;
            r_rsp_evict <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + IdxWidth'(1);
                    if (r_cnt == LastIdx) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.req_valid_i) r_state <= ST_READ;
                end
                ST_READ: begin
                    r_rsp_hit   <= w_hit;
                    r_rsp_way   <= ((r_op == OP_FILL) && !w_err) ? r_way : w_match;
                    r_rsp_dirty <= (r_op == OP_FILL) ? w_vict[EntryW-2] : w_hit_dirty;
                    r_rsp_evict <= (r_op == OP_FILL) && w_vict[EntryW-1];
                    r_rsp_tag   <= (r_op == OP_FILL) ? w_vict[TagWidth-1:0] : '0;
                    r_rsp_err   <= w_err;
                    if (w_need_wr) begin
                        r_state <= ST_WRITE;
                    end else begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Request/write-back context; only meaningful while an op is in flight
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_op    <= bus.req_op_i;
            r_idx   <= bus.req_idx_i;
            r_tag   <= bus.req_tag_i;
            r_way   <= bus.req_way_i;
            r_dirty <= bus.req_dirty_i;
        end
        if (r_state == ST_READ) begin
            r_tgt    <= w_tgt;
            r_wentry <= w_wentry;
        end
    end

    assign bus.req_ready_o = (r_state == ST_IDLE);
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_hit_o   = r_rsp_hit;
    assign bus.rsp_way_o   = r_rsp_way;
    assign bus.rsp_dirty_o = r_rsp_dirty;
    assign bus.rsp_evict_o = r_rsp_evict;
    assign bus.rsp_tag_o   = r_rsp_tag;
    assign bus.rsp_err_o   = r_rsp_err;
    assign init_done_o     = r_init_done;

    a_fill_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_accept && (bus.req_op_i == OP_FILL)) |-> $onehot(bus.req_way_i));
endmodule

// File: tb/tb_axi_llc_tag_lookup.sv
// Bench for axi_llc_tag_lookup: tag SRAM model, transaction-level reference store,
// per-cycle compare process and directed operation sequence.
module tb_axi_llc_tag_lookup;
    localparam int NumWays  = 8;
    localparam int NumLines = 256;
    localparam int TagWidth = 20;
    localparam int IdxWidth = 8;
    localparam int EntryW   = TagWidth + 2;
    localparam int BeW      = (EntryW + 7) / 8;
    localparam logic [NumWays-1:0] AllW = '1;
    localparam logic [1:0] OpLookup = 2'b00, OpLDirty = 2'b01, OpFill = 2'b10, OpInval = 2'b11;

    typedef struct {
        logic                hit;
        logic [NumWays-1:0]  way;
        logic                dirty;
        logic                evict;
        logic [TagWidth-1:0] tag;
        logic                err;
        int                  lat;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [NumWays-1:0]          sram_req_o, sram_we_o;
    logic [NumWays*IdxWidth-1:0] sram_addr_o;
    logic [NumWays*EntryW-1:0]   sram_wdata_o;
    logic [NumWays*BeW-1:0]      sram_be_o;
    logic [NumWays*EntryW-1:0]   sram_rdata;
    logic                        init_done_o;

    axi_llc_tag_lookup_if #(.NumWays(NumWays), .NumLines(NumLines), .TagWidth(TagWidth)) bus ();

    axi_llc_tag_lookup #(.NumWays(NumWays), .NumLines(NumLines), .TagWidth(TagWidth)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .init_done_o  (init_done_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_be_o    (sram_be_o),
        .sram_rdata_i (sram_rdata)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Tag SRAM model: one macro per way, 1-cycle read latency, plus scramble/backdoor hooks
    logic [EntryW-1:0] mem [NumWays][NumLines];
    logic              scramble = 1'b0;
    logic              bd_en = 1'b0;
    int                bd_way = 0, bd_idx = 0;
    logic [EntryW-1:0] bd_val = '0;

    always @(posedge clk_i) begin
        if (scramble) begin
            for (int w = 0; w < NumWays; w++)
                for (int i = 0; i < NumLines; i++)
                    mem[w][i] <= EntryW'(w * 977 + i * 31 + 5) | (EntryW'(1) << (EntryW - 1));
        end else if (bd_en) begin
            mem[bd_way][bd_idx] <= bd_val;
        end else begin
            for (int w = 0; w < NumWays; w++) begin
                if (sram_req_o[w]) begin
                    if (sram_we_o[w])
                        mem[w][sram_addr_o[w*IdxWidth +: IdxWidth]] <= sram_wdata_o[w*EntryW +: EntryW];
                    else
                        sram_rdata[w*EntryW +: EntryW] <= mem[w][sram_addr_o[w*IdxWidth +: IdxWidth]];
                end
            end
        end
    end

    // Reference tag store and the expectations of the op in flight
    logic [EntryW-1:0]  ref_mem [NumWays][NumLines];
    logic               mon_en = 1'b0;
    logic               inflight = 1'b0;
    int                 acc_cyc = 0;
    rsp_t               exp_r;
    logic               exp_need = 1'b0;
    logic [NumWays-1:0] exp_tgt = '0;
    logic [EntryW-1:0]  exp_entry = '0;
    int                 exp_idx = 0;

    task automatic model_op(input logic [1:0] op, input int idx, input logic [TagWidth-1:0] tag,
                            input logic [NumWays-1:0] way, input logic dirty, output rsp_t r,
                            output logic need, output logic [NumWays-1:0] tgt,
                            output logic [EntryW-1:0] ne);
        int nm = 0;
        int vw = 0;
        logic [NumWays-1:0] m = '0;
        logic [EntryW-1:0] e;
        for (int w = 0; w < NumWays; w++) begin
            e = ref_mem[w][idx];
            if (e[EntryW-1] && e[TagWidth-1:0] == tag) begin m[w] = 1'b1; nm++; end
            if (way[w]) vw = w;
        end
        r.err = (nm > 1);
        r.hit = (nm == 1);
        r.way = (op == OpFill && !r.err) ? way : m;
        r.dirty = 1'b0;
        for (int w = 0; w < NumWays; w++) if (m[w] && ref_mem[w][idx][EntryW-2]) r.dirty = 1'b1;
        r.evict = 1'b0;
        r.tag = '0;
        if (op == OpFill) begin
            r.dirty = ref_mem[vw][idx][EntryW-2];
            r.evict = ref_mem[vw][idx][EntryW-1];
            r.tag   = ref_mem[vw][idx][TagWidth-1:0];
        end
        case (op)
            OpLDirty: need = r.hit && !r.dirty;
            OpInval:  need = r.hit;
            OpFill:   need = !r.err;
            default:  need = 1'b0;
        endcase
        tgt = (op == OpFill) ? way : m;
        ne = (op == OpLDirty) ? {2'b11, tag} : (op == OpFill) ? {1'b1, dirty, tag} : '0;
        r.lat = need ? 3 : 2;
        if (need)
            for (int w = 0; w < NumWays; w++) if (tgt[w]) ref_mem[w][idx] = ne;
    endtask

    // Per-cycle compare of DUT outputs against the in-flight expectation
    always @(negedge clk_i) begin
        logic               exp_v;
        logic [NumWays-1:0] exp_we, exp_req;
        if (mon_en) begin
            exp_v = inflight && (cyc >= acc_cyc + (exp_need ? 3 : 2));
            chk("rsp_valid", bus.rsp_valid_o, exp_v);
            chk("req_ready", bus.req_ready_o, !inflight);
            if (exp_v) begin
                chk("rsp_hit", bus.rsp_hit_o, exp_r.hit);
                chk("rsp_way", bus.rsp_way_o, exp_r.way);
                chk("rsp_dirty", bus.rsp_dirty_o, exp_r.dirty);
                chk("rsp_evict", bus.rsp_evict_o, exp_r.evict);
                chk("rsp_tag", bus.rsp_tag_o, exp_r.tag);
                chk("rsp_err", bus.rsp_err_o, exp_r.err);
            end
            exp_we  = (inflight && exp_need && cyc == acc_cyc + 2) ? exp_tgt : '0;
            exp_req = (bus.req_valid_i && !inflight) ? AllW : exp_we;
            chk("sram_req", sram_req_o, exp_req);
            chk("sram_we", sram_we_o, exp_we);
            for (int w = 0; w < NumWays; w++) begin
                if (exp_we[w]) begin
                    chk("wr_addr", sram_addr_o[w*IdxWidth +: IdxWidth], exp_idx);
                    chk("wr_data", sram_wdata_o[w*EntryW +: EntryW], exp_entry);
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input int idx, input logic [TagWidth-1:0] tag,
                         input logic [NumWays-1:0] way, input logic dirty, input int hold,
                         output rsp_t act);
        rsp_t m;
        logic need;
        logic [NumWays-1:0] tgt;
        logic [EntryW-1:0] ne;
        int a, n;
        model_op(op, idx, tag, way, dirty, m, need, tgt, ne);
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_idx_i   = IdxWidth'(idx);
        bus.req_tag_i   = tag;
        bus.req_way_i   = way;
        bus.req_dirty_i = dirty;
        @(negedge clk_i);
        n = 0;
        while (!bus.req_ready_o && n < 20) begin @(negedge clk_i); n++; end
        chk("accept", bus.req_ready_o, 1);
        a = cyc;
        @(posedge clk_i); #1;
        exp_r = m; exp_need = need; exp_tgt = tgt; exp_entry = ne; exp_idx = idx;
        acc_cyc = a; inflight = 1'b1;
        bus.req_valid_i = 1'b0;
        @(negedge clk_i);
        n = 0;
        while (!bus.rsp_valid_o && n < 10) begin @(negedge clk_i); n++; end
        chk("rsp_arrived", bus.rsp_valid_o, 1);
        act.lat   = cyc - a;
        act.hit   = bus.rsp_hit_o;
        act.way   = bus.rsp_way_o;
        act.dirty = bus.rsp_dirty_o;
        act.evict = bus.rsp_evict_o;
        act.tag   = bus.rsp_tag_o;
        act.err   = bus.rsp_err_o;
        chk("latency", act.lat, m.lat);
        for (int i = 0; i < hold; i++) begin
            chk("hold_ready", bus.req_ready_o, 0);
            @(negedge clk_i);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        inflight = 1'b0;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic backdoor(input int w, input int idx, input logic [EntryW-1:0] val);
        @(posedge clk_i); #1;
        bd_en = 1'b1; bd_way = w; bd_idx = idx; bd_val = val;
        ref_mem[w][idx] = val;
        @(posedge clk_i); #1;
        bd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        mon_en = 1'b0; rst_ni = 1'b0; scramble = 1'b1;
        #1;
        chk("rst_init_done", init_done_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_sram_we", sram_we_o, AllW);
        chk("rst_sram_addr", sram_addr_o, 0);
        chk("rst_sram_be", sram_be_o, 24'hFFFFFF);
        @(posedge clk_i); #1;
        scramble = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic sweep(input int lim, output int n);
        n = 0;
        @(negedge clk_i);
        while (!init_done_o && n < lim) begin
            chk("init_addr", sram_addr_o, {NumWays{IdxWidth'(n)}});
            chk("init_we", sram_we_o, AllW);
            chk("init_ready", bus.req_ready_o, 0);
            @(negedge clk_i);
            n++;
        end
    endtask

    initial begin
        rsp_t r;
        int n, bad;
        bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_idx_i = '0; bus.req_tag_i = '0;
        bus.req_way_i = '0; bus.req_dirty_i = 1'b0; bus.rsp_ready_i = 1'b0;
        for (int w = 0; w < NumWays; w++)
            for (int i = 0; i < NumLines; i++) ref_mem[w][i] = '0;

        do_reset();
        sweep(100, n);
        chk("init_partial_cycles", n, 100);
        chk("init_not_done_early", init_done_o, 0);
        do_reset();
        sweep(400, n);
        chk("init_cycles", n, 256);
        chk("init_done", init_done_o, 1);
        bad = 0;
        for (int w = 0; w < NumWays; w++)
            for (int i = 0; i < NumLines; i++) if (mem[w][i] != '0) bad++;
        chk("init_zero_entries", bad, 0);
        #1 mon_en = 1'b1;

        do_op(OpLookup, 5, 20'h123, 8'h00, 1'b0, 0, r);
        chk("l1_hit", r.hit, 0);
        chk("l1_lat", r.lat, 2);
        do_op(OpFill, 5, 20'h123, 8'h04, 1'b0, 0, r);
        chk("f1_evict", r.evict, 0);
        chk("f1_lat", r.lat, 3);
        do_op(OpLookup, 5, 20'h123, 8'h00, 1'b0, 0, r);
        chk("l2_hit", r.hit, 1);
        chk("l2_way", r.way, 8'h04);
        chk("l2_dirty", r.dirty, 0);
        do_op(OpLDirty, 5, 20'h123, 8'h00, 1'b0, 0, r);
        chk("ld1_hit", r.hit, 1);
        chk("ld1_dirty", r.dirty, 0);
        chk("ld1_lat", r.lat, 3);
        do_op(OpLookup, 5, 20'h123, 8'h00, 1'b0, 0, r);
        chk("l3_dirty", r.dirty, 1);
        chk("l3_lat", r.lat, 2);
        do_op(OpFill, 5, 20'h456, 8'h04, 1'b0, 5, r);
        chk("f2_evict", r.evict, 1);
        chk("f2_tag", r.tag, 20'h123);
        chk("f2_dirty", r.dirty, 1);
        do_op(OpLookup, 5, 20'h456, 8'h00, 1'b0, 0, r);
        chk("l4_way", r.way, 8'h04);
        chk("l4_dirty", r.dirty, 0);
        do_op(OpLookup, 6, 20'h456, 8'h00, 1'b0, 0, r);
        chk("l5_other_idx_hit", r.hit, 0);
        do_op(OpFill, 5, 20'hABCDE, 8'h80, 1'b1, 0, r);
        chk("f3_evict", r.evict, 0);
        do_op(OpInval, 5, 20'h456, 8'h00, 1'b0, 0, r);
        chk("i1_hit", r.hit, 1);
        chk("i1_lat", r.lat, 3);
        do_op(OpLookup, 5, 20'h456, 8'h00, 1'b0, 0, r);
        chk("l6_after_inval", r.hit, 0);
        do_op(OpLDirty, 5, 20'hABCDE, 8'h00, 1'b0, 0, r);
        chk("ld2_dirty", r.dirty, 1);
        chk("ld2_lat", r.lat, 2);

        backdoor(1, 9, {2'b10, 20'h777});
        backdoor(6, 9, {2'b10, 20'h777});
        do_op(OpLDirty, 9, 20'h777, 8'h00, 1'b0, 0, r);
        chk("e1_err", r.err, 1);
        chk("e1_hit", r.hit, 0);
        chk("e1_way", r.way, 8'h42);
        chk("e1_lat", r.lat, 2);
        do_op(OpInval, 9, 20'h777, 8'h00, 1'b0, 0, r);
        chk("e2_err", r.err, 1);
        chk("e2_lat", r.lat, 2);

        bad = 0;
        for (int w = 0; w < NumWays; w++)
            for (int i = 0; i < NumLines; i++) if (mem[w][i] != ref_mem[w][i]) bad++;
        chk("final_store", bad, 0);

        @(posedge clk_i); #1;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
